// File: rtl/i_merge4_rr.sv
// i_merge4_rr: 4:1 packet-atomic round-robin merge with a 2-entry output skid stage.
// Optional route tagging of header beats is enabled by defining I_MERGE4_ROUTE_TAG_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | between packets; arbitrate, next accepted beat is a header
// ST_PKT  | mid-packet; only the granted port may push beats
module i_merge4_rr #(
   parameter logic [1:0] RESET_LAST_GRANT = 2'd3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        I0_TVALID,
   output logic        I0_TREADY,
   input  logic [63:0] I0_TDATA,
   input  logic        I0_TLAST,
   input  logic        I1_TVALID,
   output logic        I1_TREADY,
   input  logic [63:0] I1_TDATA,
   input  logic        I1_TLAST,
   input  logic        I2_TVALID,
   output logic        I2_TREADY,
   input  logic [63:0] I2_TDATA,
   input  logic        I2_TLAST,
   input  logic        I3_TVALID,
   output logic        I3_TREADY,
   input  logic [63:0] I3_TDATA,
   input  logic        I3_TLAST,
   output logic        O_TVALID,
   input  logic        O_TREADY,
   output logic [63:0] O_TDATA,
   output logic        O_TLAST,
   output logic [1:0]  O_GRANT,
   output logic        O_BUSY
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_PKT  = 1'b1;

   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [63:0] in_data [4];

   assign in_valid = {I3_TVALID, I2_TVALID, I1_TVALID, I0_TVALID};
   assign in_last  = {I3_TLAST, I2_TLAST, I1_TLAST, I0_TLAST};
   assign in_data[0] = I0_TDATA;
   assign in_data[1] = I1_TDATA;
   assign in_data[2] = I2_TDATA;
   assign in_data[3] = I3_TDATA;

   logic        state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        run_q;
   logic [1:0]  cnt_q, cnt_d;
   logic [64:0] ent0_q, ent0_d;
   logic [64:0] ent1_q, ent1_d;

   logic [1:0]  sel;
   logic [1:0]  arb_idx;
   logic        found;
   logic [1:0]  cur;
   logic        cur_ok;
   logic        skid_not_full;
   logic [3:0]  in_ready;
   logic        accept;
   logic        pop;
   logic [63:0] acc_data;
   logic        acc_last;
   logic [63:0] push_data;

   // Search starts just after the last packet owner, so that owner ranks lowest.
   always_comb begin
      sel     = last_q;
      arb_idx = last_q;
      found   = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         arb_idx = last_q + 2'(i);
         if (!found && in_valid[arb_idx]) begin
            sel   = arb_idx;
            found = 1'b1;
         end
      end
   end

   // run_q keeps every ready low while reset is held and for the first edge after it.
   assign skid_not_full = run_q & (cnt_q != 2'd2);
   assign cur           = (state_q == ST_IDLE) ? sel : gnt_q;
   assign cur_ok        = (state_q == ST_IDLE) ? found : 1'b1;
   assign in_ready      = (cur_ok && skid_not_full) ? (4'b0001 << cur) : 4'b0000;
   assign accept        = |(in_ready & in_valid);
   assign pop           = (cnt_q != 2'd0) & O_TREADY;

   always_comb begin
      acc_data = in_data[cur];
      acc_last = in_last[cur];
   end

`ifdef I_MERGE4_ROUTE_TAG_EN
   always_comb begin
      if (state_q == ST_IDLE) begin
         push_data = {acc_data[63:56], acc_data[53:48], cur, acc_data[47:0]};
      end else begin
         push_data = acc_data;
      end
   end
`else
   assign push_data = acc_data;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      if (accept) begin
         if (state_q == ST_IDLE) begin
            last_d = cur;
            if (!acc_last) begin
               state_d = ST_PKT;
               gnt_d   = cur;
            end
         end else if (acc_last) begin
            state_d = ST_IDLE;
         end
      end
   end

   // ent0 is always the head; a push while full cannot happen since ready was low.
   always_comb begin
      cnt_d  = cnt_q;
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      case ({accept, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               ent0_d = {acc_last, push_data};
            end else begin
               ent1_d = {acc_last, push_data};
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = {acc_last, push_data};
            end else begin
               ent0_d = ent1_q;
               ent1_d = {acc_last, push_data};
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         last_q  <= RESET_LAST_GRANT;
         gnt_q   <= 2'd0;
         run_q   <= 1'b0;
         cnt_q   <= 2'd0;
         ent0_q  <= '0;
         ent1_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         run_q   <= 1'b1;
         cnt_q   <= cnt_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
      end
   end

   assign I0_TREADY = in_ready[0];
   assign I1_TREADY = in_ready[1];
   assign I2_TREADY = in_ready[2];
   assign I3_TREADY = in_ready[3];

   assign O_TVALID = (cnt_q != 2'd0);
   assign O_TDATA  = ent0_q[63:0];
   assign O_TLAST  = O_TVALID & ent0_q[64];
   assign O_GRANT  = gnt_q;
   assign O_BUSY   = (state_q == ST_PKT);

   a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (O_TVALID && !O_TREADY) |=> (O_TVALID && $stable(O_TDATA) && $stable(O_TLAST)));

   a_one_ready: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(in_ready));

endmodule

// File: tb/tb_i_merge4_rr.sv
// Scoreboard bench for i_merge4_rr: per-port beat queues drive the inputs,
// expected output beats are queued in the order the arbiter must serve them.
module tb_i_merge4_rr;

`ifdef I_MERGE4_ROUTE_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  tv = '0;
   logic [3:0]  tl = '0;
   logic [63:0] td [4];
   logic [3:0]  tr;
   logic        O_TVALID;
   logic        O_TREADY;
   logic [63:0] O_TDATA;
   logic        O_TLAST;
   logic [1:0]  O_GRANT;
   logic        O_BUSY;

   always #5 clk = ~clk;

   i_merge4_rr dut (
      .clk(clk), .reset_n(reset_n),
      .I0_TVALID(tv[0]), .I0_TREADY(tr[0]), .I0_TDATA(td[0]), .I0_TLAST(tl[0]),
      .I1_TVALID(tv[1]), .I1_TREADY(tr[1]), .I1_TDATA(td[1]), .I1_TLAST(tl[1]),
      .I2_TVALID(tv[2]), .I2_TREADY(tr[2]), .I2_TDATA(td[2]), .I2_TLAST(tl[2]),
      .I3_TVALID(tv[3]), .I3_TREADY(tr[3]), .I3_TDATA(td[3]), .I3_TLAST(tl[3]),
      .O_TVALID(O_TVALID), .O_TREADY(O_TREADY), .O_TDATA(O_TDATA), .O_TLAST(O_TLAST),
      .O_GRANT(O_GRANT), .O_BUSY(O_BUSY)
   );

   typedef struct {
      logic [63:0] data;
      logic        last;
      int          gap;
   } beat_t;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [1:0]  src;
   } exp_t;

   beat_t src_q [4][$];
   exp_t  exp_q [$];

   int    n_chk = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    fire_n = 0;
   int    first_fire = 0;
   int    last_fire = 0;
   int    acc_cnt [4] = '{0, 0, 0, 0};
   int    p0_stall = 0;
   int    bad_p0 = 0;
   int    gapc [4] = '{0, 0, 0, 0};
   bit    fresh [4] = '{1, 1, 1, 1};
   bit    p2_open = 1'b0;
   bit    chk_grant = 1'b0;
   bit [3:0] acc = '0;
   string cur_tag = "t1";

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] xform(input logic [63:0] d, input logic [1:0] src, input logic hdr);
      return (TAG_EN && hdr) ? {d[63:56], d[53:48], src, d[47:0]} : d;
   endfunction

   function automatic logic [63:0] mkdata(input int p, input int id, input int b);
      return {4'(p), 4'hA, 8'h00, 16'(id), 16'hBEEF, 16'(b)};
   endfunction

   task automatic push_beat(input int p, input logic [63:0] d, input logic last, input int gap);
      beat_t b;
      b.data = d;
      b.last = last;
      b.gap  = gap;
      src_q[p].push_back(b);
   endtask

   task automatic push_exp(input logic [63:0] d, input logic last, input int p);
      exp_t e;
      e.data = d;
      e.last = last;
      e.src  = 2'(p);
      exp_q.push_back(e);
   endtask

   task automatic load_pkt(input int p, input int n, input int id, input bit want);
      for (int b = 0; b < n; b++) begin
         push_beat(p, mkdata(p, id, b), (b == n - 1), 0);
         if (want) push_exp(xform(mkdata(p, id, b), 2'(p), (b == 0)), (b == n - 1), p);
      end
   endtask

   task automatic wait_drain(input int limit, output bit busy_seen);
      int n;
      n = 0;
      busy_seen = 1'b0;
      while (n < limit && !(exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                            src_q[2].size() == 0 && src_q[3].size() == 0 && !O_TVALID)) begin
         @(negedge clk);
         busy_seen = busy_seen | O_BUSY;
         n++;
      end
      check_eq({cur_tag, "_drain_in_time"}, 64'(n < limit), 64'd1);
   endtask

   // Source drivers: present the head beat of each port queue after its gap.
   initial begin
      for (int p = 0; p < 4; p++) td[p] = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < 4; p++) begin
            if (acc[p]) begin
               if (src_q[p].size() > 0) void'(src_q[p].pop_front());
               fresh[p] = 1'b1;
            end
            if (src_q[p].size() == 0) begin
               tv[p]    = 1'b0;
               fresh[p] = 1'b1;
            end else begin
               if (fresh[p]) begin
                  gapc[p]  = src_q[p][0].gap;
                  fresh[p] = 1'b0;
               end
               if (gapc[p] > 0) begin
                  tv[p] = 1'b0;
                  gapc[p]--;
               end else begin
                  tv[p] = 1'b1;
                  td[p] = src_q[p][0].data;
                  tl[p] = src_q[p][0].last;
               end
            end
         end
      end
   end

   // Monitor and scoreboard, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         acc = tv & tr;
         for (int p = 0; p < 4; p++) if (acc[p]) acc_cnt[p]++;
         if (tv[0] && !tr[0]) p0_stall++;
         if (acc[0] && p2_open) bad_p0++;
         if (acc[2]) p2_open = !tl[2];
         if (reset_n && O_TVALID && O_TREADY) begin
            fire_n++;
            if (fire_n == 1) first_fire = cyc;
            last_fire = cyc;
            if (exp_q.size() == 0) begin
               check_eq({cur_tag, "_sb_nonempty"}, 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check_eq({cur_tag, "_data"}, O_TDATA, e.data);
               check_eq({cur_tag, "_last"}, 64'(O_TLAST), 64'(e.last));
               if (chk_grant) check_eq({cur_tag, "_grant"}, 64'(O_GRANT), 64'(e.src));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
      $fatal(1);
   end

   initial begin
      bit busy;
      int k;
      logic [63:0] d1;
      reset_n  = 1'b0;
      O_TREADY = 1'b1;
      // Reset with every port valid; the 4-way stream is queued up front.
      load_pkt(0, 3, 0, 1);
      load_pkt(1, 3, 1, 1);
      load_pkt(2, 3, 2, 1);
      load_pkt(3, 3, 3, 1);
      load_pkt(0, 3, 4, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("t1_rst_tvalid_in", 64'(tv), 64'hF);
      check_eq("t1_rst_tready", 64'(tr), 64'd0);
      check_eq("t1_rst_otvalid", 64'(O_TVALID), 64'd0);
      check_eq("t1_rst_otlast", 64'(O_TLAST), 64'd0);
      check_eq("t1_rst_busy", 64'(O_BUSY), 64'd0);
      check_eq("t1_rst_grant", 64'(O_GRANT), 64'd0);

      @(posedge clk); #2;
      reset_n   = 1'b1;
      cur_tag   = "t2";
      chk_grant = 1'b1;
      fire_n    = 0;
      wait_drain(200, busy);
      check_eq("t2_beats", 64'(fire_n), 64'd15);
      check_eq("t2_span", 64'(last_fire - first_fire), 64'd14);

      // Port 2 packet with valid gaps; port 0 must wait for its TLAST.
      @(posedge clk); #2;
      cur_tag  = "t3";
      p0_stall = 0;
      bad_p0   = 0;
      push_beat(2, mkdata(2, 10, 0), 1'b0, 0);
      push_beat(2, mkdata(2, 10, 1), 1'b0, 2);
      push_beat(2, mkdata(2, 10, 2), 1'b0, 2);
      push_beat(2, mkdata(2, 10, 3), 1'b1, 0);
      push_exp(xform(mkdata(2, 10, 0), 2'd2, 1'b1), 1'b0, 2);
      push_exp(mkdata(2, 10, 1), 1'b0, 2);
      push_exp(mkdata(2, 10, 2), 1'b0, 2);
      push_exp(mkdata(2, 10, 3), 1'b1, 2);
      load_pkt(0, 2, 11, 1);
      wait_drain(200, busy);
      check_eq("t3_p0_stall", 64'(p0_stall), 64'd8);
      check_eq("t3_interleave", 64'(bad_p0), 64'd0);

      // Single-beat packets from ports 1 and 3.
      @(posedge clk); #2;
      cur_tag   = "t5";
      chk_grant = 1'b0;
      fire_n    = 0;
      load_pkt(1, 1, 20, 1);
      load_pkt(3, 1, 21, 1);
      wait_drain(100, busy);
      check_eq("t5_beats", 64'(fire_n), 64'd2);
      check_eq("t5_span", 64'(last_fire - first_fire), 64'd1);
      check_eq("t5_busy", 64'(busy), 64'd0);

      // Backpressure mid-packet with a known beat at the skid head.
      @(posedge clk); #2;
      cur_tag    = "t4";
      fire_n     = 0;
      acc_cnt[1] = 0;
      for (int b = 0; b < 6; b++) begin
         logic [63:0] d;
         d = (b == 2) ? 64'h0123_4567_89AB_CDEF : mkdata(1, 30, b);
         push_beat(1, d, (b == 5), 0);
         push_exp(xform(d, 2'd1, (b == 0)), (b == 5), 1);
      end
      d1 = mkdata(1, 30, 1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(O_TVALID && O_TREADY && O_TDATA == d1) && k < 50);
      check_eq("t4_sync", 64'(k < 50), 64'd1);
      @(posedge clk); #2;
      O_TREADY = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq("t4_hold_data", O_TDATA, 64'h0123_4567_89AB_CDEF);
         check_eq("t4_hold_valid", 64'(O_TVALID), 64'd1);
      end
      check_eq("t4_tready_full", 64'(tr[1]), 64'd0);
      check_eq("t4_accepted", 64'(acc_cnt[1]), 64'd4);
      @(posedge clk); #2;
      O_TREADY = 1'b1;
      wait_drain(100, busy);
      check_eq("t4_beats", 64'(fire_n), 64'd6);

      // Header rewrite (identity when the tag feature is off).
      @(posedge clk); #2;
      cur_tag = "t6";
      push_beat(2, 64'hAA3F_0000_0000_1234, 1'b0, 0);
      push_beat(2, 64'hAA3F_0000_0000_5678, 1'b1, 0);
      push_exp(TAG_EN ? 64'hAAFE_0000_0000_1234 : 64'hAA3F_0000_0000_1234, 1'b0, 2);
      push_exp(64'hAA3F_0000_0000_5678, 1'b1, 2);
      wait_drain(100, busy);

      // Reset while the skid holds two beats.
      @(posedge clk); #2;
      cur_tag    = "t7";
      O_TREADY   = 1'b0;
      acc_cnt[0] = 0;
      load_pkt(0, 5, 40, 0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(acc_cnt[0] >= 2 && tr[0] == 1'b0) && k < 30);
      check_eq("t7_sync", 64'(k < 30), 64'd1);
      check_eq("t7_skid_full_valid", 64'(O_TVALID), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("t7_rst_otvalid", 64'(O_TVALID), 64'd0);
      check_eq("t7_rst_otlast", 64'(O_TLAST), 64'd0);
      check_eq("t7_rst_tready", 64'(tr), 64'd0);
      check_eq("t7_rst_busy", 64'(O_BUSY), 64'd0);
      src_q[0].delete();
      exp_q.delete();
      @(posedge clk);
      @(posedge clk); #2;
      reset_n   = 1'b1;
      O_TREADY  = 1'b1;
      chk_grant = 1'b1;
      fire_n    = 0;
      load_pkt(3, 2, 41, 1);
      wait_drain(100, busy);
      check_eq("t7_beats", 64'(fire_n), 64'd2);
      check_eq("t7_busy_after_hdr", 64'(busy), 64'd1);

      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
